// File: rtl/round_pkg.sv
// Shared types and default constants for the round sequencer.
// The watchdog option is enabled with the ROUND_CTRL_TIMEOUT_EN macro.
package round_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DATA_W_DEF      = 128;
  localparam int LAST_CNT        = 17;
  localparam int CNT_W           = 5;
  localparam int TIMEOUT_CYC_DEF = 32;

endpackage

// File: rtl/round_wdt.sv
// Watchdog for the round sequencer: counts RUN cycles since the last accept
// and flags when the limit is reached. Instantiated only with ROUND_CTRL_TIMEOUT_EN.
module round_wdt #(
  parameter int LIMIT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [5:0] wdt;

  assign expired = run && (wdt == 6'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt <= '0;
    end else if (clear) begin
      wdt <= '0;
    end else if (run && !expired) begin
      wdt <= wdt + 6'd1;
    end
  end

endmodule

// File: rtl/round_ctrl.sv
// Handshake front-end and sequencer for the iterative round datapath.
// Optional watchdog abort is compiled in with `define ROUND_CTRL_TIMEOUT_EN.
module round_ctrl
  import round_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int LAST_CNT    = round_pkg::LAST_CNT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] blk_q,
  output logic              load,
  output logic              start,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              cnt_end,
  output logic              round_en,
  output logic [CNT_W-1:0]  round_idx,
  input  logic [DATA_W-1:0] res_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);

  state_t state, state_next;
  logic   accept;
  logic   capture;
  logic   timeout;

  assign accept    = (state == IDLE) && in_valid;
  assign capture   = (state == RUN) && cnt_end;
  assign round_idx = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = RUN;
      RUN: begin
        if (cnt_end) begin
          state_next = DONE;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // start follows RUN directly so a reset drops it without waiting for an edge
  always_comb begin
    in_ready  = 1'b0;
    start     = 1'b0;
    out_valid = 1'b0;
    round_en  = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        start    = 1'b1;
        round_en = ~cnt_end;
      end
      DONE: out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q    <= '0;
      load     <= 1'b0;
      out_data <= '0;
    end else begin
      load <= accept;
      if (accept) begin
        blk_q <= in_data;
      end
      if (capture) begin
        out_data <= res_data;
      end
    end
  end

`ifdef ROUND_CTRL_TIMEOUT_EN
  // Never let the watchdog fire before a healthy counter could finish
  localparam int WDT_LIMIT = (TIMEOUT_CYC > LAST_CNT) ? TIMEOUT_CYC : LAST_CNT + 1;

  logic wdt_hit;

  round_wdt #(
    .LIMIT(WDT_LIMIT)
  ) u_wdt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .run    (state == RUN),
    .expired(wdt_hit)
  );

  assign timeout = wdt_hit & ~cnt_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (timeout) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = (TIMEOUT_CYC > LAST_CNT);
  assign timeout    = 1'b0;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl with a behavioural round counter and
// datapath (result = ~block); expectations come from the sequencing rules.
module tb_round_ctrl;

  localparam int DATA_W = 128;
  localparam logic [DATA_W-1:0] ONE = 128'd1;
  localparam logic [DATA_W-1:0] ZERO = 128'd0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] blk_q;
  logic              load;
  logic              start;
  logic [4:0]        cnt;
  logic              cnt_end;
  logic              round_en;
  logic [4:0]        round_idx;
  logic [DATA_W-1:0] res_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [4:0] cnt_m = 5'd0;
  logic       end_m = 1'b0;
  logic       force_end = 1'b0;
  logic       kill_end = 1'b0;

  round_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .blk_q    (blk_q),
    .load     (load),
    .start    (start),
    .cnt      (cnt),
    .cnt_end  (cnt_end),
    .round_en (round_en),
    .round_idx(round_idx),
    .res_data (res_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .err      (err)
  );

  always #5 clk = ~clk;

  // External round counter: clears while start is low, counts to 17 then holds
  always @(posedge clk) begin
    if (!start) begin
      cnt_m <= 5'd0;
      end_m <= 1'b0;
    end else if (!end_m) begin
      cnt_m <= cnt_m + 5'd1;
      end_m <= !kill_end && ((cnt_m + 5'd1) == 5'd17);
    end
  end

  assign cnt      = cnt_m;
  assign cnt_end  = end_m | force_end;
  assign res_data = ~blk_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic applyStimulus(input logic [DATA_W-1:0] data, input bit keep);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = data;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    checkOutput("accept_ready", 128'(in_ready), ONE);
    step();
    if (!keep) in_valid = 1'b0;
    checkOutput("accept_load", 128'(load), ONE);
    checkOutput("accept_blk_q", blk_q, data);
    checkOutput("accept_start", 128'(start), ONE);
    checkOutput("accept_in_ready", 128'(in_ready), ZERO);
  endtask

  // Called just after the accept edge; expects 17 enabled rounds then a result at 18
  task automatic waitResult(input logic [DATA_W-1:0] data, input string tag);
    int n;
    int en_cnt;
    int load_cnt;
    n = 0;
    en_cnt = 0;
    load_cnt = 0;
    while (!out_valid && n < 40) begin
      if (load) load_cnt++;
      if (round_en) begin
        checkOutput({tag, "_round_idx"}, 128'(round_idx), 128'(en_cnt));
        en_cnt++;
      end
      step();
      n++;
    end
    checkOutput({tag, "_latency"}, 128'(n), 128'(18));
    checkOutput({tag, "_round_en_cycles"}, 128'(en_cnt), 128'(17));
    checkOutput({tag, "_load_cycles"}, 128'(load_cnt), ONE);
    checkOutput({tag, "_out_data"}, out_data, ~data);
    checkOutput({tag, "_blk_q_kept"}, blk_q, data);
    checkOutput({tag, "_start_low"}, 128'(start), ZERO);
    checkOutput({tag, "_err"}, 128'(err), ZERO);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] d2;
    int n;
    int seen;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("rst_in_ready", 128'(in_ready), ONE);
    checkOutput("rst_start", 128'(start), ZERO);
    checkOutput("rst_load", 128'(load), ZERO);
    checkOutput("rst_out_valid", 128'(out_valid), ZERO);
    checkOutput("rst_err", 128'(err), ZERO);
    checkOutput("rst_blk_q", blk_q, ZERO);
    checkOutput("rst_out_data", out_data, ZERO);
    checkOutput("rst_round_en", 128'(round_en), ZERO);

    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    applyStimulus(d, 1'b0);
    waitResult(d, "first");

    // Downstream stall with spurious cnt_end pulses while DONE
    for (int i = 0; i < 10; i++) begin
      force_end = (i >= 3 && i < 6);
      step();
      checkOutput("stall_out_valid", 128'(out_valid), ONE);
      checkOutput("stall_out_data", out_data, ~d);
      checkOutput("stall_in_ready", 128'(in_ready), ZERO);
    end
    force_end = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("release_out_valid", 128'(out_valid), ZERO);
    checkOutput("release_in_ready", 128'(in_ready), ONE);

    force_end = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();
    checkOutput("idle_spur_in_ready", 128'(in_ready), ONE);
    checkOutput("idle_spur_start", 128'(start), ZERO);
    checkOutput("idle_spur_out_valid", 128'(out_valid), ZERO);
    checkOutput("idle_spur_out_data", out_data, ~d);
    force_end = 1'b0;
    out_ready = 1'b0;
    step();

    for (int j = 0; j < 3; j++) begin
      d = rand128();
      applyStimulus(d, 1'b0);
      waitResult(d, "rand");
      n = $urandom_range(0, 4);
      repeat (n) begin
        step();
        checkOutput("rand_hold_valid", 128'(out_valid), ONE);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checkOutput("rand_release", 128'(out_valid), ZERO);
    end

    // Back-to-back: in_valid never drops; the new block appears on in_data mid-run
    d  = rand128();
    d2 = rand128();
    out_ready = 1'b1;
    applyStimulus(d, 1'b1);
    in_data = d2;
    waitResult(d, "b2b_a");
    step();
    checkOutput("b2b_hs_out_valid", 128'(out_valid), ZERO);
    checkOutput("b2b_hs_in_ready", 128'(in_ready), ONE);
    checkOutput("b2b_hs_blk_q", blk_q, d);
    step();
    in_valid = 1'b0;
    checkOutput("b2b_second_load", 128'(load), ONE);
    checkOutput("b2b_second_blk_q", blk_q, d2);
    checkOutput("b2b_second_idx", 128'(round_idx), ZERO);
    checkOutput("b2b_second_round_en", 128'(round_en), ONE);
    waitResult(d2, "b2b_b");
    step();
    out_ready = 1'b0;
    checkOutput("b2b_b_release", 128'(out_valid), ZERO);

    // Reset in the middle of a run
    d = rand128();
    applyStimulus(d, 1'b0);
    n = 0;
    while (round_idx != 5'd8 && n < 30) begin
      step();
      n++;
    end
    checkOutput("mid_rst_reach_idx8", 128'(round_idx), 128'(8));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_start", 128'(start), ZERO);
    checkOutput("mid_rst_out_valid", 128'(out_valid), ZERO);
    checkOutput("mid_rst_err", 128'(err), ZERO);
    checkOutput("mid_rst_blk_q", blk_q, ZERO);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (25) begin
      step();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checkOutput("mid_rst_no_result", 128'(seen), ZERO);
    checkOutput("mid_rst_cnt_cleared", 128'(cnt), ZERO);
    d = rand128();
    applyStimulus(d, 1'b0);
    waitResult(d, "post_rst");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput("post_rst_release", 128'(out_valid), ZERO);

`ifdef ROUND_CTRL_TIMEOUT_EN
    kill_end = 1'b1;
    d = rand128();
    applyStimulus(d, 1'b0);
    n = 0;
    seen = 0;
    while (start && n < 60) begin
      if (out_valid) seen++;
      step();
      n++;
    end
    checkOutput("wdt_run_cycles", 128'(n), 128'(32));
    checkOutput("wdt_err", 128'(err), ONE);
    checkOutput("wdt_no_valid", 128'(seen + int'(out_valid)), ZERO);
    checkOutput("wdt_idle", 128'(in_ready), ONE);
    kill_end = 1'b0;
    step();
    checkOutput("wdt_err_sticky", 128'(err), ONE);
    d = rand128();
    applyStimulus(d, 1'b0);
    checkOutput("wdt_err_cleared", 128'(err), ZERO);
    waitResult(d, "wdt_next");
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
Name: round_ctrl

Overview:
Handshake front-end and sequencer for the iterative round datapath.
- Accepts one data block over valid/ready and drives `start` into the round counter.
- Watches the counter's `cnt`/`cnt_end` and exports the round enable and round index to the datapath.
- Captures the datapath result when rounds complete and holds it on a valid/ready output until consumed.

Parameters:
- DATA_W, 128, width of input block and result.
- LAST_CNT, 17, counter value at which `cnt_end` is raised; informational, used by the watchdog bound.
- TIMEOUT_CYC, 32, watchdog limit in RUN cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream block valid
- in_ready  out  1  block accepted on in_valid&in_ready
- in_data  in  DATA_W  plaintext/key block
- blk_q  out  DATA_W  registered copy of accepted block for datapath load
- load  out  1  one-cycle pulse: datapath loads blk_q
- start  out  1  to counter start input
- cnt  in  5  counter round index
- cnt_end  in  1  counter done flag
- round_en  out  1  datapath advances one round this cycle
- round_idx  out  5  equals cnt
- res_data  in  DATA_W  datapath result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  captured result
- err  out  1  watchdog abort flag (0 when feature absent)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; start, load, out_valid, err = 0; blk_q, out_data = 0.
  - in_ready=1 immediately after reset release.
- FSM states:
  - IDLE: in_ready=1. On in_valid at edge T0: blk_q<=in_data, load<=1 for one cycle, start<=1, go RUN.
  - RUN: in_ready=0; start held 1.
    - round_en = (state==RUN) & ~cnt_end; round_idx=cnt combinationally.
    - On an edge with cnt_end=1: out_data<=res_data, out_valid<=1, start<=0, go DONE.
  - DONE: in_ready=0; out_valid held, out_data stable. On out_valid&out_ready: out_valid<=0, go IDLE.
- Counter interaction: `start` is low at the accept edge, so the counter clears cnt to 0 and cnt_end to 0 at that edge.
  - No extra idle cycle is required between jobs; the DONE and IDLE states already guarantee start low for at least one edge.
- Latency with the standard counter:
  - cnt=k after edge Tk; cnt_end=1 after T17.
  - Result captured at T18; out_valid visible after T18, i.e. 18 cycles accept-to-valid.
  - round_en is high for the 17 cycles following T0.
- cnt_end seen in IDLE or DONE is ignored.
- out_ready asserted while out_valid=0 is ignored.
- Simultaneous out handshake and in_valid in DONE: no accept that cycle; the block is accepted on the next cycle in IDLE. Throughput is therefore 1 block per 20 cycles minimum.
- in_valid held while in_ready=0 must not alter blk_q.
- Reset mid-RUN: start drops asynchronously; the counter clears on the next edge; no out_valid is produced for the aborted block.

Optional Feature:
- Macro: ROUND_CTRL_TIMEOUT_EN.
- With the macro:
  - A 6-bit wdt counter clears on accept and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC without cnt_end, the block drops start, sets err=1, and returns to IDLE with no out_valid.
  - err is sticky until the next accept.
- Without the macro: no watchdog logic; err tied to 0.

Decomposition:
- Package round_pkg:
  - state enum {IDLE, RUN, DONE};
  - constants DATA_W_DEF=128, LAST_CNT=17, CNT_W=5, TIMEOUT_CYC_DEF=32.
- Natural sub-module round_wdt (watchdog counter plus compare), instantiated only under ROUND_CTRL_TIMEOUT_EN.
- The existing counter stays external and is connected by the parent.

Test Plan:
- Reset release, in_data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 with model counter, res_data=~blk_q → out_valid 18 cycles after accept; out_data=~in_data; load high 1 cycle; round_en high exactly 17 cycles with round_idx 0..16.
- out_ready held 0 for 10 cycles after out_valid → out_valid and out_data stable; in_ready=0 throughout; release → out_valid drops next edge.
- Back-to-back: in_valid continuously high, out_ready=1 → second accept exactly 1 cycle after output handshake; counter starts from cnt=0.
- rst_n pulsed low at cnt=8 → start, out_valid, err immediately 0; no result emitted; a next block completes normally in 18 cycles.
- Spurious cnt_end=1 forced in IDLE and DONE → no state change, no capture.
- (ROUND_CTRL_TIMEOUT_EN, TIMEOUT_CYC=32) cnt_end stuck 0 → after 32 RUN cycles start=0, err=1, no out_valid; err clears on next accept.
